stopwatch_ctrl: RTL and testbench

Sequencing controller for the two-digit BCD counter chain (units + tens, 00–99) on the UPduino 3.1. Turns debounced start/stop, clear and lap pulses into a one-cycle counting enable and a clear strobe for the chain. Derives the counting tick from `clk` with a programmable prescaler. Produces a lap-freezable display copy of the digits plus running and overflow status.

---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencing controller for a two-digit BCD stopwatch counter chain.
// Converts start/stop, clear and lap pulses into a prescaled count enable and a
// clear strobe, and keeps a lap-freezable registered copy of the digits.
// Build option: define STOPWATCH_WRAP_EN to let the chain wrap 99->00 (flagging
// overflow) instead of saturating at 99 in the FULL state.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 12000000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  input  logic [3:0] digit_1_in,
  input  logic [3:0] digit_10_in,
  input  logic       carry_in,
  output logic       count_en,
  output logic       count_clr,
  output logic [3:0] disp_1,
  output logic [3:0] disp_10,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  localparam int unsigned DIG_W = 4;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   presc, presc_nxt;
  logic [DIG_W-1:0]   hold_1, hold_1_nxt;
  logic [DIG_W-1:0]   hold_10, hold_10_nxt;
  logic [DIG_W-1:0]   disp_1_nxt, disp_10_nxt;
  logic               count_en_nxt, count_clr_nxt, running_nxt;
  logic               lap_hold_nxt, overflow_nxt;
  logic               tick_due;
  logic               sat_hit;

  // A tick is due on the last prescaler count while running.
  assign tick_due = (state == RUN) && (presc == TICK_LAST);

`ifdef STOPWATCH_WRAP_EN
  // Wrap mode: the chain handles 99->00 itself, never saturate.
  assign sat_hit = 1'b0;
`else
  // Saturate mode: a due tick at 99 parks the stopwatch instead of counting.
  logic carry_unused;
  assign carry_unused = carry_in;
  assign sat_hit = tick_due && (digit_1_in == DIG_W'(9)) && (digit_10_in == DIG_W'(9));
`endif

  // Next-state and next-output logic; clear > start_stop > lap.
  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    count_en_nxt  = 1'b0;
    count_clr_nxt = 1'b0;
    lap_hold_nxt  = lap_hold;
    overflow_nxt  = overflow;
    hold_1_nxt    = hold_1;
    hold_10_nxt   = hold_10;

    // Prescaler advances in RUN, holds in PAUSE so a resumed run keeps its fraction.
    case (state)
      RUN:     presc_nxt = tick_due ? '0 : presc + DIV_W'(1);
      PAUSE:   presc_nxt = presc;
      default: presc_nxt = '0;
    endcase

`ifdef STOPWATCH_WRAP_EN
    if (count_en && carry_in) overflow_nxt = 1'b1;
`endif

    if (clear) begin
      state_nxt     = IDLE;
      presc_nxt     = '0;
      count_clr_nxt = 1'b1;
      lap_hold_nxt  = 1'b0;
      overflow_nxt  = 1'b0;
    end else if (sat_hit) begin
      state_nxt    = FULL;
      presc_nxt    = '0;
      overflow_nxt = 1'b1;
    end else begin
      count_en_nxt = tick_due;
      if (start_stop) begin
        case (state)
          IDLE:    state_nxt = RUN;
          RUN:     state_nxt = PAUSE;
          PAUSE:   state_nxt = RUN;
          default: state_nxt = state;
        endcase
      end else if (lap && (state == RUN || state == PAUSE)) begin
        if (lap_hold) begin
          lap_hold_nxt = 1'b0;
        end else begin
          lap_hold_nxt = 1'b1;
          hold_1_nxt   = digit_1_in;
          hold_10_nxt  = digit_10_in;
        end
      end
    end

    running_nxt = (state_nxt == RUN);
    disp_1_nxt  = lap_hold_nxt ? hold_1_nxt  : digit_1_in;
    disp_10_nxt = lap_hold_nxt ? hold_10_nxt : digit_10_in;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      running   <= 1'b0;
      lap_hold  <= 1'b0;
      overflow  <= 1'b0;
      hold_1    <= '0;
      hold_10   <= '0;
      disp_1    <= '0;
      disp_10   <= '0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      count_en  <= count_en_nxt;
      count_clr <= count_clr_nxt;
      running   <= running_nxt;
      lap_hold  <= lap_hold_nxt;
      overflow  <= overflow_nxt;
      hold_1    <= hold_1_nxt;
      hold_10   <= hold_10_nxt;
      disp_1    <= disp_1_nxt;
      disp_10   <= disp_10_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with TICK_DIV=4 and a
// behavioural two-digit BCD counter chain driven by count_en/count_clr.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss, clr, lp;
  logic [3:0] ch_1, ch_10;
  logic       carry;
  logic       count_en, count_clr, running, lap_hold, overflow;
  logic [3:0] disp_1, disp_10;
  logic       ld;
  logic [3:0] ld_1, ld_10;
  int         tests = 0;
  int         fails = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .reset(reset), .start_stop(ss), .clear(clr), .lap(lp),
    .digit_1_in(ch_1), .digit_10_in(ch_10), .carry_in(carry),
    .count_en(count_en), .count_clr(count_clr), .disp_1(disp_1), .disp_10(disp_10),
    .running(running), .lap_hold(lap_hold), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Counter chain model: clear > preload > increment, wraps 99 -> 00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_1 <= 4'd0; ch_10 <= 4'd0;
    end else if (count_clr) begin
      ch_1 <= 4'd0; ch_10 <= 4'd0;
    end else if (ld) begin
      ch_1 <= ld_1; ch_10 <= ld_10;
    end else if (count_en) begin
      if (ch_1 == 4'd9) begin
        ch_1  <= 4'd0;
        ch_10 <= (ch_10 == 4'd9) ? 4'd0 : ch_10 + 4'd1;
      end else begin
        ch_1 <= ch_1 + 4'd1;
      end
    end
  end
  assign carry = count_en && (ch_1 == 4'd9) && (ch_10 == 4'd9);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; ss = 1'b0; clr = 1'b0; lp = 1'b0;
    ld = 1'b0; ld_1 = 4'd0; ld_10 = 4'd0;

    // Reset values
    repeat (3) tick();
    check("rst_count_en", 8'(count_en), 8'd0);
    check("rst_count_clr", 8'(count_clr), 8'd0);
    check("rst_running", 8'(running), 8'd0);
    check("rst_lap_hold", 8'(lap_hold), 8'd0);
    check("rst_overflow", 8'(overflow), 8'd0);
    check("rst_disp", {disp_10, disp_1}, 8'h00);
    reset = 1'b1;
    repeat (2) tick();

    // Start at cycle T: running at T+1, ticks at T+5, T+9, T+13
    ss = 1'b1; tick(); ss = 1'b0;
    check("start_running", 8'(running), 8'd1);
    check("start_en", 8'(count_en), 8'd0);
    for (int k = 2; k <= 13; k++) begin
      tick();
      check("en_cadence", 8'(count_en), 8'((k == 5) || (k == 9) || (k == 13)));
    end
    tick(); tick();
    check("disp_03", {disp_10, disp_1}, 8'h03);

    // Pause with prescaler at 2, resume 20 cycles later
    ss = 1'b1; tick(); ss = 1'b0;
    check("pause_running", 8'(running), 8'd0);
    check("pause_en", 8'(count_en), 8'd0);
    for (int k = 2; k <= 20; k++) begin
      tick();
      check("en_while_paused", 8'(count_en), 8'd0);
    end
    ss = 1'b1; tick(); ss = 1'b0;
    check("resume_running", 8'(running), 8'd1);
    check("resume_en_r1", 8'(count_en), 8'd0);
    tick();
    check("resume_en_r2", 8'(count_en), 8'd1);
    tick();
    check("resume_en_r3", 8'(count_en), 8'd0);

    // Lap at 05, frozen while chain reaches 08, then release
    repeat (4) tick();
    lp = 1'b1; tick(); lp = 1'b0;
    check("lap_hold_set", 8'(lap_hold), 8'd1);
    check("lap_disp_05", {disp_10, disp_1}, 8'h05);
    repeat (10) tick();
    check("lap_en_continues", 8'(count_en), 8'd1);
    tick();
    check("lap_frozen", {disp_10, disp_1}, 8'h05);
    lp = 1'b1; tick(); lp = 1'b0;
    check("lap_released", 8'(lap_hold), 8'd0);
    check("lap_disp_live", {disp_10, disp_1}, 8'h08);

    // Clear + start_stop + lap together while running with lap held
    lp = 1'b1; tick(); lp = 1'b0;
    check("lap_hold_again", 8'(lap_hold), 8'd1);
    clr = 1'b1; ss = 1'b1; lp = 1'b1; tick(); clr = 1'b0; ss = 1'b0; lp = 1'b0;
    check("clr_strobe", 8'(count_clr), 8'd1);
    check("clr_running", 8'(running), 8'd0);
    check("clr_lap_hold", 8'(lap_hold), 8'd0);
    check("clr_overflow", 8'(overflow), 8'd0);
    check("clr_no_tick", 8'(count_en), 8'd0);
    tick();
    check("clr_one_cycle", 8'(count_clr), 8'd0);
    tick();
    check("clr_disp", {disp_10, disp_1}, 8'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("idle_no_en", 8'(count_en), 8'd0);
    end

    // Chain preloaded to 99, run into the due tick
    ld = 1'b1; ld_1 = 4'd9; ld_10 = 4'd9; ss = 1'b1; tick(); ld = 1'b0; ss = 1'b0;
    check("max_running", 8'(running), 8'd1);
    repeat (3) tick();
    check("max_en_pre", 8'(count_en), 8'd0);
    tick();
`ifdef STOPWATCH_WRAP_EN
    check("wrap_en", 8'(count_en), 8'd1);
    check("wrap_ovf_pre", 8'(overflow), 8'd0);
    tick();
    check("wrap_overflow", 8'(overflow), 8'd1);
    check("wrap_running", 8'(running), 8'd1);
    tick();
    check("wrap_disp", {disp_10, disp_1}, 8'h00);
`else
    check("sat_no_en", 8'(count_en), 8'd0);
    check("sat_running", 8'(running), 8'd0);
    check("sat_overflow", 8'(overflow), 8'd1);
    ss = 1'b1; tick(); ss = 1'b0;
    check("sat_ss_ignored", 8'(running), 8'd0);
    check("sat_ovf_sticky", 8'(overflow), 8'd1);
    tick();
    check("sat_disp", {disp_10, disp_1}, 8'h99);
    check("sat_no_en2", 8'(count_en), 8'd0);
`endif
    clr = 1'b1; tick(); clr = 1'b0;
    check("max_clr_strobe", 8'(count_clr), 8'd1);
    check("max_clr_overflow", 8'(overflow), 8'd0);
    check("max_clr_running", 8'(running), 8'd0);
    tick();

    // Asynchronous reset mid-RUN
    ss = 1'b1; tick(); ss = 1'b0;
    lp = 1'b1; tick(); lp = 1'b0;
    check("pre_rst_lap", 8'(lap_hold), 8'd1);
    repeat (3) tick();
    check("pre_rst_en", 8'(count_en), 8'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_count_en", 8'(count_en), 8'd0);
    check("arst_running", 8'(running), 8'd0);
    check("arst_lap_hold", 8'(lap_hold), 8'd0);
    check("arst_count_clr", 8'(count_clr), 8'd0);
    check("arst_overflow", 8'(overflow), 8'd0);
    check("arst_disp", {disp_10, disp_1}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("post_rst_idle", {6'd0, running, count_en}, 8'd0);
      check("post_rst_no_clr", 8'(count_clr), 8'd0);
    end
    ss = 1'b1; tick(); ss = 1'b0;
    check("post_rst_start", 8'(running), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
